// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: issues word fetches at pc, hands instructions to IF/ID with
// zero added latency, parks an instruction while ID stalls, and handles delay-slot branches and exception flushes.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_stall_i,
   input  logic        id_branch_i,
   input  logic [31:0] id_branch_target_i,
   input  logic        ex_exception_i,
   output logic        imem_read_o,
   output logic [31:0] imem_address_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] if_instruction_o,
   output logic [31:0] if_pc_add_4_o,
   output logic [31:0] if_pc_usable_o,
   output logic        if_stall_o,
   output logic        if_flush_o,
   output logic        if_bra_delay_o
);

   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic        redir_q, redir_d;
   logic        valid, advance, br_new;
   logic [31:0] pc_add4, br_target;

   assign pc_add4   = pc_q + 32'd4;
   assign br_target = {id_branch_target_i[31:2], 2'b00};
   // Reset gating keeps the outputs quiet combinationally while rst_ni is low.
   assign valid     = rst_ni & (((state_q == FETCH) & imem_ready_i) | (state_q == HOLD));
   assign advance   = valid & ~id_stall_i & ~ex_exception_i;
   assign br_new    = id_branch_i & ~id_stall_i & ~redir_q;

   always_comb begin
      imem_read_o    = rst_ni & (state_q != HOLD);
      imem_address_o = pc_q;
      if_pc_usable_o = pc_q;
      if_pc_add_4_o  = pc_add4;
      if_stall_o     = ~valid | ex_exception_i;
      if_flush_o     = rst_ni & ex_exception_i;
      if_bra_delay_o = redir_q & ~valid;
      case (state_q)
         FETCH:   if_instruction_o = imem_data_i;
         HOLD:    if_instruction_o = hold_q;
         default: if_instruction_o = 32'h0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      hold_d     = hold_q;
      redir_d    = redir_q;
      redir_pc_d = redir_pc_q;
      if (ex_exception_i) begin
         // A request still in flight must have its response swallowed.
         state_d = ((state_q != HOLD) & ~imem_ready_i) ? DISCARD : FETCH;
         pc_d    = EXC_VECTOR;
         hold_d  = 32'h0;
         redir_d = 1'b0;
      end else if (advance) begin
         // With no pending redirect, a branch seen now makes the current IF word its delay slot.
         state_d = FETCH;
         redir_d = 1'b0;
         if (redir_q)     pc_d = redir_pc_q;
         else if (br_new) pc_d = br_target;
         else             pc_d = pc_add4;
      end else begin
         if (br_new) begin
            redir_d    = 1'b1;
            redir_pc_d = br_target;
         end
         if ((state_q == DISCARD) & imem_ready_i) begin
            state_d = FETCH;
         end else if ((state_q == FETCH) & imem_ready_i & id_stall_i) begin
            state_d = HOLD;
            hold_d  = imem_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= FETCH;
         pc_q       <= RESET_VECTOR;
         hold_q     <= 32'h0;
         redir_q    <= 1'b0;
         redir_pc_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         hold_q     <= hold_d;
         redir_q    <= redir_d;
         redir_pc_q <= redir_pc_d;
      end
   end

endmodule
